// File: rtl/ysyx_23060096_seq_pkg.sv
// Shared types and RISC-V encodings for the NPC multi-cycle sequencer.
package ysyx_23060096_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  // Only these opcodes produce a register result; rd==x0 discards it.
  function automatic logic writes_rd(input logic [31:0] inst);
    logic op_writes;
    unique case (inst[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: op_writes = 1'b1;
      default:                      op_writes = 1'b0;
    endcase
    return op_writes && (inst[11:7] != 5'd0);
  endfunction

endpackage

// File: rtl/ysyx_23060096_core_seq_if.sv
// Fetch and load/store handshake bundle between the sequencer (master) and memories (slave).
interface ysyx_23060096_core_seq_if;
  logic        ifu_req;
  logic        ifu_ack;
  logic [31:0] ifu_inst;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_ack;

  modport master (
    output ifu_req, lsu_req, lsu_we,
    input  ifu_ack, ifu_inst, lsu_ack
  );

  modport slave (
    input  ifu_req, lsu_req, lsu_we,
    output ifu_ack, ifu_inst, lsu_ack
  );
endinterface

// File: rtl/ysyx_23060096_seq_wdog.sv
// Wait-state watchdog shared by the FETCH and MEM handshakes.
module ysyx_23060096_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/ysyx_23060096_core_seq.sv
// Multi-cycle NPC sequencer: fetch/decode/exec/mem/wb with IR, write strobes and timeout trap.
// Optional performance counters enabled by YSYX_23060096_PERF_CNT_EN.
module ysyx_23060096_core_seq
  import ysyx_23060096_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_23060096_core_seq_if.master bus,
  output logic [31:0]              inst_q,
  output logic                     pc_we,
  output logic                     rf_we,
  output logic                     halted,
  output logic                     err,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instret_cnt
);

  state_e state;
  logic   ifu_req_q;
  logic   lsu_req_q;
  logic   lsu_we_q;
  logic   expired;
  logic   waiting;
  logic   is_mem_op;
  logic   is_store;
  logic   rd_write;

  assign is_store  = (inst_q[6:0] == OPC_STORE);
  assign is_mem_op = is_store || (inst_q[6:0] == OPC_LOAD);
  assign rd_write  = writes_rd(inst_q);

  // The counter only runs while a handshake is outstanding; any ack, timeout
  // or other state leaves it cleared, so each request starts from zero.
  assign waiting = ((state == S_FETCH) && !bus.ifu_ack) ||
                   ((state == S_MEM)   && !bus.lsu_ack);

  ysyx_23060096_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!waiting || expired),
    .inc    (waiting && !expired),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inst_q    <= INST_NOP;
      ifu_req_q <= 1'b0;
      lsu_req_q <= 1'b0;
      lsu_we_q  <= 1'b0;
      pc_we     <= 1'b0;
      rf_we     <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      pc_we <= 1'b0;
      rf_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          ifu_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.ifu_ack) begin
            inst_q    <= bus.ifu_inst;
            ifu_req_q <= 1'b0;
            state     <= S_DECODE;
          end else if (expired) begin
            ifu_req_q <= 1'b0;
            err       <= 1'b1;
            state     <= S_ERROR;
          end
        end
        S_DECODE: begin
          if (inst_q == INST_EBREAK) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem_op) begin
            lsu_req_q <= 1'b1;
            lsu_we_q  <= is_store;
            state     <= S_MEM;
          end else begin
            pc_we <= 1'b1;
            rf_we <= rd_write;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.lsu_ack) begin
            lsu_req_q <= 1'b0;
            lsu_we_q  <= 1'b0;
            pc_we     <= 1'b1;
            rf_we     <= rd_write;
            state     <= S_WB;
          end else if (expired) begin
            lsu_req_q <= 1'b0;
            lsu_we_q  <= 1'b0;
            err       <= 1'b1;
            state     <= S_ERROR;
          end
        end
        S_WB: begin
          ifu_req_q <= 1'b1;
          state     <= S_FETCH;
        end
        S_HALT, S_ERROR: begin
          state <= state;
        end
      endcase
    end
  end

  assign bus.ifu_req = ifu_req_q;
  assign bus.lsu_req = lsu_req_q;
  assign bus.lsu_we  = lsu_we_q;

`ifdef YSYX_23060096_PERF_CNT_EN
  logic [63:0] cycle_q;
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT && state != S_ERROR)
        cycle_q <= cycle_q + 64'd1;
      // ebreak retires on its way into HALT, without a WB cycle.
      if (state == S_WB || (state == S_DECODE && inst_q == INST_EBREAK))
        instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060096_core_seq.sv
// Directed bench for ysyx_23060096_core_seq: vector table of instructions plus corner sequences.
module tb_ysyx_23060096_core_seq;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_q;
  logic        pc_we;
  logic        rf_we;
  logic        halted;
  logic        err;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  ysyx_23060096_core_seq_if bus ();

  ysyx_23060096_core_seq #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .inst_q     (inst_q),
    .pc_we      (pc_we),
    .rf_we      (rf_we),
    .halted     (halted),
    .err        (err),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    int          lsu_wait;
    int          exp_wb;
    int          exp_lsu;
    logic        exp_lsu_we;
    logic        exp_rf_we;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    bus.ifu_ack  = 1'b0;
    bus.lsu_ack  = 1'b0;
    bus.ifu_inst = 32'h0;
    step();
    step();
    check("rst_ifu_req", bus.ifu_req, 1'b0);
    check("rst_lsu_req", bus.lsu_req, 1'b0);
    check("rst_strobes", {pc_we, rf_we}, 2'b00);
    check("rst_flags", {halted, err}, 2'b00);
    check("rst_inst_q", inst_q, NOP);
    check("rst_cycle_cnt", cycle_cnt, 64'd0);
    check("rst_instret_cnt", instret_cnt, 64'd0);
    rst = 1'b0;
    step();
  endtask

  // Starts at a FETCH cycle; stray acks are driven in every non-waiting cycle.
  task automatic run_vec(input vec_t v);
    int   n;
    int   lsu_n;
    logic we_seen;
    logic rf_seen;
    logic wb_seen;
    check({v.name, "_fetch_entry"}, bus.ifu_req, 1'b1);
    bus.ifu_inst = v.inst;
    bus.ifu_ack  = 1'b1;
    bus.lsu_ack  = 1'b1;
    n = 0; lsu_n = 0; we_seen = 1'b0; rf_seen = 1'b0; wb_seen = 1'b0;
    while (!wb_seen && n < 40) begin
      step();
      n++;
      bus.ifu_inst = 32'hFFFF_FFFF;
      bus.ifu_ack  = 1'b1;
      if (bus.lsu_req) begin
        lsu_n++;
        we_seen     = we_seen | bus.lsu_we;
        bus.lsu_ack = (lsu_n == v.lsu_wait + 1);
      end else begin
        bus.lsu_ack = 1'b1;
      end
      if (pc_we) begin
        wb_seen     = 1'b1;
        rf_seen     = rf_we;
        bus.ifu_ack = 1'b0;
        bus.lsu_ack = 1'b0;
      end
    end
    check({v.name, "_wb_cycle"}, 64'(n + 1), 64'(v.exp_wb));
    check({v.name, "_lsu_cycles"}, 64'(lsu_n), 64'(v.exp_lsu));
    if (v.exp_lsu > 0) check({v.name, "_lsu_we"}, we_seen, v.exp_lsu_we);
    check({v.name, "_rf_we"}, rf_seen, v.exp_rf_we);
    check({v.name, "_inst_q"}, inst_q, v.inst);
    step();
    check({v.name, "_post_wb"}, {pc_we, rf_we, bus.ifu_req, bus.lsu_req}, 4'b0010);
  endtask

  initial begin
    int   n;
    int   exp_cycles;
    logic odd;

    vecs[0]  = '{"add",    32'h003100B3, 0, 4, 0, 1'b0, 1'b1};
    vecs[1]  = '{"lw",     32'h00002283, 3, 8, 4, 1'b0, 1'b1};
    vecs[2]  = '{"sw",     32'h00502023, 0, 5, 1, 1'b1, 1'b0};
    vecs[3]  = '{"addi_x0",32'h00100013, 0, 4, 0, 1'b0, 1'b0};
    vecs[4]  = '{"lui",    32'h000003B7, 0, 4, 0, 1'b0, 1'b1};
    vecs[5]  = '{"auipc",  32'h00000517, 0, 4, 0, 1'b0, 1'b1};
    vecs[6]  = '{"beq",    32'h00000063, 0, 4, 0, 1'b0, 1'b0};
    vecs[7]  = '{"jal",    32'h000000EF, 0, 4, 0, 1'b0, 1'b1};
    vecs[8]  = '{"jalr_x0",32'h00008067, 0, 4, 0, 1'b0, 1'b0};
    vecs[9]  = '{"fence",  32'h0000000F, 0, 4, 0, 1'b0, 1'b0};
    vecs[10] = '{"ecall",  32'h00000073, 0, 4, 0, 1'b0, 1'b0};

    bus.ifu_ack  = 1'b0;
    bus.lsu_ack  = 1'b0;
    bus.ifu_inst = 32'h0;

    // Main instruction stream, then ebreak.
    reset_dut();
    exp_cycles = 0;
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      exp_cycles += vecs[i].exp_wb;
    end

    bus.ifu_inst = EBREAK;
    bus.ifu_ack  = 1'b1;
    step();
    bus.ifu_ack = 1'b0;
    check("ebreak_decode", {bus.ifu_req, halted}, 2'b00);
    step();
    check("ebreak_halted", halted, 1'b1);
    for (int i = 0; i < 6; i++) begin
      odd         = (i % 2) == 1;
      bus.ifu_ack = odd;
      bus.lsu_ack = !odd;
      step();
      check($sformatf("halt_sticky_%0d", i),
            {bus.ifu_req, bus.lsu_req, pc_we, rf_we, halted, err}, 6'b000010);
    end
`ifdef YSYX_23060096_PERF_CNT_EN
    // ebreak adds its FETCH and DECODE cycles and retires on entry to HALT.
    check("perf_cycle_cnt", cycle_cnt, 64'(exp_cycles + 2));
    check("perf_instret_cnt", instret_cnt, 64'd12);
`else
    check("perf_cycle_cnt_off", cycle_cnt, 64'd0);
    check("perf_instret_cnt_off", instret_cnt, 64'd0);
`endif

    // Fetch timeout with no ack.
    reset_dut();
    n = 0;
    while (bus.ifu_req && n < 20) begin
      n++;
      step();
    end
    check("fetch_timeout_cycles", 64'(n), 64'd5);
    check("fetch_timeout_err", err, 1'b1);
    bus.ifu_ack = 1'b1;
    bus.lsu_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("err_sticky_%0d", i),
            {bus.ifu_req, bus.lsu_req, pc_we, rf_we, halted, err}, 6'b000001);
    end

    // Memory timeout on a load.
    reset_dut();
    bus.ifu_inst = 32'h00002283;
    bus.ifu_ack  = 1'b1;
    step();
    bus.ifu_ack = 1'b0;
    step();
    step();
    n = 0;
    while (bus.lsu_req && n < 20) begin
      n++;
      step();
    end
    check("mem_timeout_cycles", 64'(n), 64'd5);
    check("mem_timeout_err", {err, pc_we}, 2'b10);

    // Reset mid-MEM with a pending ack.
    reset_dut();
    bus.ifu_inst = 32'h00502023;
    bus.ifu_ack  = 1'b1;
    step();
    bus.ifu_ack = 1'b0;
    step();
    step();
    check("mid_mem_req", {bus.lsu_req, bus.lsu_we}, 2'b11);
    step();
    rst         = 1'b1;
    bus.lsu_ack = 1'b1;
    step();
    check("mid_mem_rst_outputs",
          {bus.ifu_req, bus.lsu_req, bus.lsu_we, pc_we, rf_we, err}, 6'b000000);
    check("mid_mem_rst_inst_q", inst_q, NOP);
    rst         = 1'b0;
    bus.lsu_ack = 1'b0;
    step();
    check("mid_mem_refetch", {bus.ifu_req, bus.lsu_req, pc_we}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
